// File: rtl/encoder_step_sequencer_if.sv
// Move-command handshake bundle for the encoder step sequencer.
// The master (requester) presents a command; the slave (sequencer) reports readiness.
interface encoder_step_sequencer_if #(
    parameter int CNT_W = 16,
    parameter int DIV_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_steps;
    logic [DIV_W-1:0] cmd_period;

    modport master (
        output cmd_valid,
        output cmd_dir,
        output cmd_steps,
        output cmd_period,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_dir,
        input  cmd_steps,
        input  cmd_period,
        output cmd_ready
    );
endinterface

// File: rtl/encoder_step_sequencer.sv
// Step scheduler for the quadrature encoder emulator.
// Accepts a move (direction, step count, inter-step period), emits that many
// one-cycle horario/antihorario strobes at the programmed spacing, tracks the
// signed absolute position and supports mid-move abort.
module encoder_step_sequencer #(
    parameter int CNT_W = 16,
    parameter int DIV_W = 16,
    parameter int POS_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    encoder_step_sequencer_if.slave cmd,
    input  logic                    abort,
    output logic                    horario,
    output logic                    antihorario,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic [CNT_W-1:0]        steps_left,
    output logic signed [POS_W-1:0] position
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic             dir_q;
    logic [DIV_W-1:0] period_m1;
    logic [DIV_W-1:0] timer;
    logic             strobe;

    // Abort gates the strobe combinationally so the coinciding step is suppressed;
    // async reset of state drops the strobes immediately.
    always_comb begin
        strobe      = (state == S_RUN) && (timer == '0) && !abort;
        horario     = strobe && dir_q;
        antihorario = strobe && !dir_q;
    end

    assign cmd.cmd_ready = (state == S_IDLE);
    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);

    // Sequencer FSM: command capture, step timing, position tracking and abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            dir_q      <= 1'b0;
            period_m1  <= '0;
            timer      <= '0;
            aborted    <= 1'b0;
            steps_left <= '0;
            position   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd.cmd_valid) begin
                        dir_q      <= cmd.cmd_dir;
                        // A zero period behaves as one cycle between strobes.
                        period_m1  <= (cmd.cmd_period == '0) ? '0
                                                             : cmd.cmd_period - DIV_W'(1);
                        steps_left <= cmd.cmd_steps;
                        timer      <= '0;
                        aborted    <= 1'b0;
                        state      <= (cmd.cmd_steps == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        aborted <= 1'b1;
                        state   <= S_DONE;
                    end else if (timer == '0) begin
                        steps_left <= steps_left - CNT_W'(1);
                        timer      <= period_m1;
                        position   <= dir_q ? position + POS_W'(1) : position - POS_W'(1);
                        if (steps_left == CNT_W'(1)) begin
                            state <= S_DONE;
                        end
                    end else begin
                        timer <= timer - DIV_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/encoder_step_sequencer.md
# encoder_step_sequencer

Command-driven step scheduler that generates the `horario` / `antihorario` step strobes for the quadrature encoder emulator. It accepts a move command over a valid/ready handshake: direction, step count and inter-step period. It then issues exactly that many one-cycle strobes at the programmed spacing. It also tracks the signed absolute position the encoder has been driven to and supports mid-move abort.

## Interface

Parameters:
- `CNT_W`, 16: width of step count and `steps_left`.
- `DIV_W`, 16: width of inter-step period.
- `POS_W`, 32: width of the signed position counter.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: reset. Asynchronous, active-high.
- `cmd_valid`, input, 1: command present.
- `cmd_ready`, output, 1: sequencer can accept a command.
- `cmd_dir`, input, 1: 1 = horario (clockwise), 0 = antihorario.
- `cmd_steps`, input, CNT_W: number of steps to issue.
- `cmd_period`, input, DIV_W: cycles between strobes; 0 is treated as 1.
- `abort`, input, 1: terminate the active move.
- `horario`, output, 1: clockwise step strobe to the encoder.
- `antihorario`, output, 1: counter-clockwise step strobe to the encoder.
- `busy`, output, 1: high whenever state ≠ IDLE.
- `done`, output, 1: one-cycle completion pulse.
- `aborted`, output, 1: status of the last completed move; 1 if it ended by abort. Valid from `done` until the next accept.
- `steps_left`, output, CNT_W: steps not yet issued in the current or last move.
- `position`, output, POS_W, signed: +1 per horario strobe, −1 per antihorario strobe.

## Operation

- States: IDLE, RUN, DONE.
- IDLE:
  - `cmd_ready` = 1.
  - Accept occurs when `cmd_valid && cmd_ready` at a rising edge. On accept, latch dir, steps and period (0→1); set `steps_left` = `cmd_steps`; set timer = 0; clear `aborted`.
  - If `cmd_steps` = 0, go to DONE. Otherwise go to RUN.
- RUN:
  - `cmd_ready` = 0. `cmd_valid` is ignored; the requester holds it.
  - Strobe condition: timer = 0 and `abort` = 0. The strobe drives `horario` = dir or `antihorario` = !dir, combinationally from registered state.
  - On a strobe edge: `steps_left` −1, timer ← period−1, `position` ±1. If `steps_left` was 1, go to DONE.
  - If timer ≠ 0, timer −1.
  - `abort` high in RUN takes priority over a strobe. No strobe is issued that cycle, `aborted` ← 1, go to DONE, and `steps_left` holds its value.
- DONE: `done` = 1 for one cycle, `cmd_ready` = 0, then go to IDLE.
- `abort` in IDLE or DONE is ignored.
- `horario` and `antihorario` are never high simultaneously and are never high outside RUN.
- `position` wraps modulo 2^POS_W with no saturation. It is not cleared by commands, only by `rst`.

## Timing

- Reset values: state IDLE, `cmd_ready` = 1, `horario` = `antihorario` = 0, `busy` = 0, `done` = 0, `aborted` = 0, `steps_left` = 0, `position` = 0.
- Asserting `rst` mid-move forces the strobes low immediately, asynchronously. No further steps are issued after release.
- Let accept happen at the edge ending cycle C, with N steps and effective period P:
  - Strobe n (n = 0..N−1) is high during cycle C+1+n·P.
  - `done` is high during cycle C+2+(N−1)·P.
  - `cmd_ready` returns high the following cycle.
- N = 0: `done` is high in cycle C+1 and no strobes are issued.
- P = 1: strobes are issued on back-to-back cycles.
- `position` and `steps_left` update at the edge that ends each strobe cycle.
- Abort sampled at the edge ending cycle A while in RUN:
  - A strobe coinciding with A is suppressed.
  - `done` is high in cycle A+1.
- Minimum command-to-command spacing is one IDLE cycle after DONE.

## Test plan

- Reset: assert `rst` asynchronously mid-cycle → all outputs read their reset values immediately; `cmd_ready` = 1.
- N = 4, P = 0, dir = 1 → `horario` high on C+1..C+4, `antihorario` never high; `done` at C+5; `position` = 4; `steps_left` = 0; `aborted` = 0.
- N = 3, P = 5, dir = 0 → `antihorario` at C+1, C+6, C+11; `done` at C+12; `position` = −3 (0xFFFFFFFD); `cmd_valid` pulses during RUN are not accepted.
- N = 0 → `done` at C+1, no strobes, `position` unchanged.
- N = 10, P = 2, abort in the cycle of the 4th strobe → 3 strobes only; `done` the next cycle; `aborted` = 1; `steps_left` = 7; `position` = 3.
- POS_W = 4, from 0, N = 1 antihorario → `position` = 0xF. Then N = 2 horario → `position` = 0x1. Then `rst` mid-move of N = 5 → strobes stop immediately; `position` = 0.
